// File: rtl/mips_stage_sequencer_if.sv
// Handshake/status bundle between the instruction front end and the
// mips_stage_sequencer. The master side (front end / bench) drives start,
// opcode and stall; the slave side (sequencer) drives state, stage enables,
// pulses and the performance counters.
interface mips_stage_sequencer_if #(
    parameter int CNT_W = 32,
    parameter int OP_W  = 6
) ();
    logic             start;
    logic [OP_W-1:0]  opcode;
    logic             stall;
    logic [2:0]       state;
    logic [4:0]       stage_en;
    logic             busy;
    logic             instr_done;
    logic             illegal;
    logic [CNT_W-1:0] cycle_count;
    logic [CNT_W-1:0] instr_count;

    modport master (
        output start, opcode, stall,
        input  state, stage_en, busy, instr_done, illegal, cycle_count, instr_count
    );

    modport slave (
        input  start, opcode, stall,
        output state, stage_en, busy, instr_done, illegal, cycle_count, instr_count
    );
endinterface

// File: rtl/mips_stage_sequencer.sv
// Opcode-aware multicycle stage sequencer for the MIPS core.
// Walks each instruction through only the stages its class needs, holds in
// FETCH/MEMORY on memory stalls and flags illegal opcodes in DECODE.
// Optional feature macro: SEQ_PERF_COUNTERS_EN builds the cycle/instruction
// counters; without it both counter outputs are constant zero.
//
// state     | code | meaning
// ----------+------+-----------------------------------------------
// FETCH     |  0   | instruction fetch, holds while stall=1
// DECODE    |  1   | opcode decoded, class latched on exit
// EXECUTE   |  2   | ALU / branch resolve
// MEMORY    |  3   | data memory access, holds while stall=1
// WRITEBACK |  4   | register file write
// IDLE      |  7   | no instruction in flight
module mips_stage_sequencer #(
    parameter int CNT_W = 32,
    parameter int OP_W  = 6
) (
    input logic                    clock,
    input logic                    reset,
    mips_stage_sequencer_if.slave  bus
);

    localparam logic [2:0] S_FETCH     = 3'd0;
    localparam logic [2:0] S_DECODE    = 3'd1;
    localparam logic [2:0] S_EXECUTE   = 3'd2;
    localparam logic [2:0] S_MEMORY    = 3'd3;
    localparam logic [2:0] S_WRITEBACK = 3'd4;
    localparam logic [2:0] S_IDLE      = 3'd7;

    // addi shares the R-type path, so it shares the class code.
    localparam logic [2:0] C_RTYPE = 3'd0;
    localparam logic [2:0] C_LW    = 3'd1;
    localparam logic [2:0] C_SW    = 3'd2;
    localparam logic [2:0] C_BEQ   = 3'd3;
    localparam logic [2:0] C_J     = 3'd4;

    logic [2:0]      r_state;
    logic [2:0]      r_class;
    logic [2:0]      w_next_state;
    logic [2:0]      w_dec_class;
    logic            w_dec_legal;
    logic [OP_W-1:0] w_op_hi_bits;
    logic            w_op_upper;
    logic [5:0]      w_op_lo;
    logic            w_done_raw;
    logic            w_instr_done;
    logic            w_illegal;
    logic            w_busy;
    logic [4:0]      w_stage_en;

    assign w_op_hi_bits = bus.opcode >> 6;
    assign w_op_upper   = |w_op_hi_bits;
    assign w_op_lo      = bus.opcode[5:0];

    // Class decode of the live opcode; any upper opcode bit makes it illegal.
    always_comb begin
        w_dec_class = C_RTYPE;
        w_dec_legal = 1'b1;
        case (w_op_lo)
            6'h00:   w_dec_class = C_RTYPE;
            6'h08:   w_dec_class = C_RTYPE;
            6'h23:   w_dec_class = C_LW;
            6'h2B:   w_dec_class = C_SW;
            6'h04:   w_dec_class = C_BEQ;
            6'h02:   w_dec_class = C_J;
            default: w_dec_legal = 1'b0;
        endcase
        if (w_op_upper) begin
            w_dec_legal = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Latch the decoded class when leaving DECODE; later stages never see the live opcode.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_class <= C_RTYPE;
        end else if (r_state == S_DECODE && w_dec_legal) begin
            r_class <= w_dec_class;
        end
    end

    // Next-state logic: skip unused stages, hold on stall in FETCH/MEMORY.
    always_comb begin
        w_next_state = S_IDLE;
        case (r_state)
            S_IDLE: begin
                w_next_state = bus.start ? S_FETCH : S_IDLE;
            end
            S_FETCH: begin
                w_next_state = bus.stall ? S_FETCH : S_DECODE;
            end
            S_DECODE: begin
                if (!w_dec_legal || w_dec_class == C_J) begin
                    w_next_state = bus.start ? S_FETCH : S_IDLE;
                end else begin
                    w_next_state = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                case (r_class)
                    C_BEQ:       w_next_state = bus.start ? S_FETCH : S_IDLE;
                    C_LW, C_SW:  w_next_state = S_MEMORY;
                    default:     w_next_state = S_WRITEBACK;
                endcase
            end
            S_MEMORY: begin
                if (bus.stall) begin
                    w_next_state = S_MEMORY;
                end else if (r_class == C_SW) begin
                    w_next_state = bus.start ? S_FETCH : S_IDLE;
                end else begin
                    w_next_state = S_WRITEBACK;
                end
            end
            S_WRITEBACK: begin
                w_next_state = bus.start ? S_FETCH : S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Output decode: enables from state only, pulses from state/class/opcode/stall.
    always_comb begin
        w_stage_en = 5'b00000;
        w_busy     = (r_state != S_IDLE);
        w_done_raw = 1'b0;
        w_illegal  = 1'b0;
        case (r_state)
            S_FETCH:     w_stage_en = 5'b00001;
            S_DECODE:    w_stage_en = 5'b00010;
            S_EXECUTE:   w_stage_en = 5'b00100;
            S_MEMORY:    w_stage_en = 5'b01000;
            S_WRITEBACK: w_stage_en = 5'b10000;
            default:     w_stage_en = 5'b00000;
        endcase
        case (r_state)
            S_DECODE: begin
                w_done_raw = w_dec_legal && (w_dec_class == C_J);
                w_illegal  = !w_dec_legal;
            end
            S_EXECUTE:   w_done_raw = (r_class == C_BEQ);
            S_MEMORY:    w_done_raw = !bus.stall && (r_class == C_SW);
            S_WRITEBACK: w_done_raw = 1'b1;
            default:     w_done_raw = 1'b0;
        endcase
        // A cycle that is being reset retires nothing and flags nothing.
        if (reset) begin
            w_done_raw = 1'b0;
            w_illegal  = 1'b0;
        end
        w_instr_done = w_done_raw;
    end

    assign bus.state      = r_state;
    assign bus.stage_en   = w_stage_en;
    assign bus.busy       = w_busy;
    assign bus.instr_done = w_instr_done;
    assign bus.illegal    = w_illegal;

`ifdef SEQ_PERF_COUNTERS_EN
    logic [CNT_W-1:0] r_cycle_cnt;
    logic [CNT_W-1:0] r_instr_cnt;

    // Busy-cycle and retired-instruction counters, wrapping naturally.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cycle_cnt <= '0;
            r_instr_cnt <= '0;
        end else begin
            if (w_busy) begin
                r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
            end
            if (w_instr_done) begin
                r_instr_cnt <= r_instr_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.cycle_count = r_cycle_cnt;
    assign bus.instr_count = r_instr_cnt;
`else
    assign bus.cycle_count = {CNT_W{1'b0}};
    assign bus.instr_count = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_mips_stage_sequencer.sv
// Directed testbench for mips_stage_sequencer. Counter expectations follow
// the build: with SEQ_PERF_COUNTERS_EN the hand-computed counts, else zero.
module tb_mips_stage_sequencer;

    localparam int CNT_W = 4;
    localparam int OP_W  = 6;
`ifdef SEQ_PERF_COUNTERS_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   tests_run    = 0;
    int   tests_failed = 0;

    mips_stage_sequencer_if #(.CNT_W(CNT_W), .OP_W(OP_W)) bus ();

    mips_stage_sequencer #(.CNT_W(CNT_W), .OP_W(OP_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    function automatic logic [CNT_W-1:0] cexp(input int v);
        return PERF ? CNT_W'(v) : '0;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.start = 1'b0;
        bus.stall = 1'b0;
        bus.opcode = '0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if (bus.state !== 3'd7) begin tests_failed++; $display("FAIL reset_state got %0d want 7", bus.state); end
        tests_run++;
        if (bus.stage_en !== 5'b0 || bus.busy !== 1'b0) begin tests_failed++; $display("FAIL reset_en_busy got %b/%b want 00000/0", bus.stage_en, bus.busy); end
        tests_run++;
        if (bus.instr_done !== 1'b0 || bus.illegal !== 1'b0) begin tests_failed++; $display("FAIL reset_pulses got %b/%b want 0/0", bus.instr_done, bus.illegal); end
        tests_run++;
        if (bus.cycle_count !== '0 || bus.instr_count !== '0) begin tests_failed++; $display("FAIL reset_counters got %0d/%0d want 0/0", bus.cycle_count, bus.instr_count); end
        // stall and start low: stays idle
        tick();
        tests_run++;
        if (bus.state !== 3'd7) begin tests_failed++; $display("FAIL idle_hold got %0d want 7", bus.state); end
    endtask

    task automatic test_lw();
        logic [2:0] st [5];
        st = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
        do_reset();
        bus.start = 1'b1;
        bus.opcode = 6'h23;
        tick();
        for (int i = 0; i < 5; i++) begin
            tests_run++;
            if (bus.state !== st[i] || bus.stage_en !== (5'b00001 << i) || bus.instr_done !== (i == 4) || bus.illegal !== 1'b0)
            begin
                tests_failed++;
                $display("FAIL lw_step%0d got st=%0d en=%b done=%b ill=%b want st=%0d en=%b done=%b ill=0",
                         i, bus.state, bus.stage_en, bus.instr_done, bus.illegal, st[i], 5'b00001 << i, i == 4);
            end
            // opcode change after DECODE must not alter the latched lw path
            if (i == 2) bus.opcode = 6'h04;
            tick();
        end
        tests_run++;
        if (bus.state !== 3'd0) begin tests_failed++; $display("FAIL lw_next got %0d want 0", bus.state); end
        tests_run++;
        if (bus.cycle_count !== cexp(5) || bus.instr_count !== cexp(1)) begin
            tests_failed++; $display("FAIL lw_counters got %0d/%0d want %0d/%0d", bus.cycle_count, bus.instr_count, cexp(5), cexp(1));
        end
    endtask

    task automatic test_classes();
        logic [5:0]  ops   [3];
        int          lens  [3];
        logic [11:0] paths [3];
        logic [11:0] p;
        ops   = '{6'h00, 6'h08, 6'h04};
        lens  = '{4, 4, 3};
        paths = '{{3'd4, 3'd2, 3'd1, 3'd0}, {3'd4, 3'd2, 3'd1, 3'd0}, {3'd0, 3'd2, 3'd1, 3'd0}};
        for (int k = 0; k < 3; k++) begin
            do_reset();
            bus.start = 1'b1;
            bus.opcode = ops[k];
            p = paths[k];
            tick();
            for (int i = 0; i < lens[k]; i++) begin
                tests_run++;
                if (bus.state !== p[3*i +: 3] || bus.instr_done !== (i == lens[k] - 1)) begin
                    tests_failed++;
                    $display("FAIL class_op%h_step%0d got st=%0d done=%b want st=%0d done=%b",
                             ops[k], i, bus.state, bus.instr_done, p[3*i +: 3], i == lens[k] - 1);
                end
                tick();
            end
            tests_run++;
            if (bus.state !== 3'd0) begin tests_failed++; $display("FAIL class_op%h_next got %0d want 0", ops[k], bus.state); end
        end
    endtask

    task automatic test_sw_stall();
        do_reset();
        bus.start = 1'b1;
        bus.opcode = 6'h2B;
        tick();
        tick();
        tick();
        bus.stall = 1'b1;
        tests_run++;
        if (bus.state !== 3'd2) begin tests_failed++; $display("FAIL sw_exec_ignores_stall got %0d want 2", bus.state); end
        tick();
        for (int i = 0; i < 4; i++) begin
            if (i == 3) bus.stall = 1'b0;
            #1;
            tests_run++;
            if (bus.state !== 3'd3 || bus.instr_done !== (i == 3)) begin
                tests_failed++;
                $display("FAIL sw_mem_cycle%0d got st=%0d done=%b want st=3 done=%b", i, bus.state, bus.instr_done, i == 3);
            end
            tick();
        end
        tests_run++;
        if (bus.state !== 3'd0) begin tests_failed++; $display("FAIL sw_next got %0d want 0", bus.state); end
        tests_run++;
        if (bus.cycle_count !== cexp(7) || bus.instr_count !== cexp(1)) begin
            tests_failed++; $display("FAIL sw_counters got %0d/%0d want %0d/%0d", bus.cycle_count, bus.instr_count, cexp(7), cexp(1));
        end
    endtask

    task automatic test_j();
        do_reset();
        bus.start = 1'b1;
        bus.opcode = 6'h02;
        bus.stall = 1'b1;
        tick();
        tick();
        tests_run++;
        if (bus.state !== 3'd0) begin tests_failed++; $display("FAIL j_fetch_stall got %0d want 0", bus.state); end
        bus.stall = 1'b0;
        tick();
        bus.start = 1'b0;
        #1;
        tests_run++;
        if (bus.state !== 3'd1 || bus.instr_done !== 1'b1 || bus.illegal !== 1'b0) begin
            tests_failed++; $display("FAIL j_decode got st=%0d done=%b ill=%b want st=1 done=1 ill=0", bus.state, bus.instr_done, bus.illegal);
        end
        tick();
        tests_run++;
        if (bus.state !== 3'd7 || bus.busy !== 1'b0) begin tests_failed++; $display("FAIL j_to_idle got st=%0d busy=%b want 7/0", bus.state, bus.busy); end
        tests_run++;
        if (bus.cycle_count !== cexp(3) || bus.instr_count !== cexp(1)) begin
            tests_failed++; $display("FAIL j_counters got %0d/%0d want %0d/%0d", bus.cycle_count, bus.instr_count, cexp(3), cexp(1));
        end
    endtask

    task automatic test_illegal();
        logic [5:0] bad [2];
        bad = '{6'h3F, 6'h05};
        for (int k = 0; k < 2; k++) begin
            do_reset();
            bus.start = 1'b1;
            bus.opcode = bad[k];
            tick();
            tick();
            tests_run++;
            if (bus.state !== 3'd1 || bus.illegal !== 1'b1 || bus.instr_done !== 1'b0) begin
                tests_failed++;
                $display("FAIL illegal_%h_decode got st=%0d ill=%b done=%b want st=1 ill=1 done=0", bad[k], bus.state, bus.illegal, bus.instr_done);
            end
            tick();
            tests_run++;
            if (bus.state !== 3'd0 || bus.illegal !== 1'b0) begin
                tests_failed++; $display("FAIL illegal_%h_next got st=%0d ill=%b want st=0 ill=0", bad[k], bus.state, bus.illegal);
            end
            tests_run++;
            if (bus.instr_count !== '0 || bus.cycle_count !== cexp(2)) begin
                tests_failed++; $display("FAIL illegal_%h_counters got %0d/%0d want %0d/0", bad[k], bus.cycle_count, bus.instr_count, cexp(2));
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.start = 1'b1;
        bus.opcode = 6'h23;
        tick();
        tick();
        tick();
        tests_run++;
        if (bus.state !== 3'd2) begin tests_failed++; $display("FAIL rmid_in_exec got %0d want 2", bus.state); end
        tick();
        tick();
        reset = 1'b1;
        bus.start = 1'b0;
        bus.stall = 1'b1;
        #1;
        tests_run++;
        if (bus.state !== 3'd4 || bus.instr_done !== 1'b0) begin
            tests_failed++; $display("FAIL rmid_no_pulse got st=%0d done=%b want st=4 done=0", bus.state, bus.instr_done);
        end
        tick();
        reset = 1'b0;
        bus.stall = 1'b0;
        tests_run++;
        if (bus.state !== 3'd7 || bus.instr_done !== 1'b0 || bus.illegal !== 1'b0 || bus.cycle_count !== '0 || bus.instr_count !== '0) begin
            tests_failed++;
            $display("FAIL rmid_after got st=%0d done=%b ill=%b cc=%0d ic=%0d want 7/0/0/0/0",
                     bus.state, bus.instr_done, bus.illegal, bus.cycle_count, bus.instr_count);
        end
        tick();
        tick();
        tests_run++;
        if (bus.state !== 3'd7) begin tests_failed++; $display("FAIL rmid_stays_idle got %0d want 7", bus.state); end
    endtask

    task automatic test_back_to_back();
        logic [2:0] st [4];
        int dones;
        st = '{3'd0, 3'd1, 3'd2, 3'd4};
        dones = 0;
        do_reset();
        bus.start = 1'b1;
        bus.opcode = 6'h00;
        tick();
        for (int i = 0; i < 20; i++) begin
            tests_run++;
            if (bus.state !== st[i % 4]) begin
                tests_failed++; $display("FAIL b2b_cycle%0d got %0d want %0d", i, bus.state, st[i % 4]);
            end
            if (bus.instr_done === 1'b1) dones++;
            tick();
        end
        tests_run++;
        if (dones != 5 || bus.state !== 3'd0) begin tests_failed++; $display("FAIL b2b_dones got %0d st=%0d want 5 st=0", dones, bus.state); end
        tests_run++;
        if (bus.cycle_count !== cexp(4) || bus.instr_count !== cexp(5)) begin
            tests_failed++; $display("FAIL b2b_counters got %0d/%0d want %0d/%0d", bus.cycle_count, bus.instr_count, cexp(4), cexp(5));
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.stall = 1'b0;
        bus.opcode = '0;
        test_reset();
        test_lw();
        test_classes();
        test_sw_stall();
        test_j();
        test_illegal();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
